// File: rtl/hamming_decoder_pipe.sv
// hamming_decoder_pipe: streaming Hamming(7,4) single-error-correcting decoder.
// Two registered stages (syndrome, then correct) with valid/ready on both sides,
// plus saturating counters of delivered and corrected words.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_code[6:0]    codeword {p1,p2,d1,p3,d2,d3,d4}; code position k = bit [7-k]
//   in_valid/ready  input handshake (in_ready is combinational from out_ready)
//   out_data[3:0]   corrected data {d1,d2,d3,d4}
//   out_syndrome    {s3,s2,s1}; 0 = clean, else erroneous code position 1..7
//   out_corrected   a bit was flipped (syndrome non-zero)
//   out_valid/ready output handshake; out_* come straight from flops
//   cnt_clr         synchronous clear of both counters (wins over a handshake)
//   word_cnt        delivered words, saturating at 2^CNT_W-1
//   corr_cnt        delivered words with out_corrected=1, saturating
module hamming_decoder_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    localparam int unsigned CODE_W = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // stage 1 registers
    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [SYN_W-1:0]  s1_syn;

    // handshake / flow-control terms
    logic              in_fire;
    logic              out_fire;
    logic              s2_adv;
    logic              s1_adv;

    // combinational datapath
    logic [SYN_W-1:0]  syn_c;
    logic [CODE_W-1:0] flip_mask_c;
    logic [CODE_W-1:0] fixed_code_c;
    logic [DATA_W-1:0] fixed_data_c;

    // Flow control: stage 2 frees up when empty or being drained this cycle.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s1_adv;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Syndrome of the incoming word; each bit checks the positions whose index has that bit set.
    always_comb begin
        syn_c    = '0;
        syn_c[0] = in_code[6] ^ in_code[4] ^ in_code[2] ^ in_code[0];
        syn_c[1] = in_code[5] ^ in_code[4] ^ in_code[1] ^ in_code[0];
        syn_c[2] = in_code[3] ^ in_code[2] ^ in_code[1] ^ in_code[0];
    end

    // Stage 1: capture codeword and syndrome on each input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_code  <= in_code;
                s1_syn   <= syn_c;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Correction: syndrome S names code position S, which lives at bit [7-S].
    // A double error yields a valid-looking S and is silently miscorrected.
    always_comb begin
        flip_mask_c = '0;
        for (int i = 0; i < int'(CODE_W); i++) begin
            flip_mask_c[i] = (s1_syn == SYN_W'(7 - i));
        end
        fixed_code_c = s1_code ^ flip_mask_c;
        fixed_data_c = {fixed_code_c[4], fixed_code_c[2], fixed_code_c[1], fixed_code_c[0]};
    end

    // Stage 2: output registers; payload only loads when a word moves in, so it holds under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data      <= fixed_data_c;
                out_syndrome  <= s1_syn;
                out_corrected <= (s1_syn != '0);
            end
        end
    end

    // Statistics: count output handshakes, saturate at all-ones, clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (cnt_clr) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (out_fire) begin
            if (word_cnt != CNT_MAX) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (out_corrected && (corr_cnt != CNT_MAX)) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
